// File: rtl/vote_session_ctrl_pkg.sv
// Shared types for the ballot controller: candidate index, button bundle,
// vote count and the ballot FSM state encoding.
package vote_pkg;

  localparam int NUM_CAND = 4;

  typedef logic [1:0]          cand_idx_t;
  typedef logic [NUM_CAND-1:0] btn_t;
  typedef logic [7:0]          count_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_WAIT_REL = 3'd4,
    ST_RESULT   = 3'd5
  } state_t;

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Front-panel / counter-block bundle for the ballot controller.
interface vote_session_ctrl_if;
  import vote_pkg::*;

  logic                        mode;
  logic                        arm;
  btn_t                        button;
  count_t [NUM_CAND-1:0]       vote_recv_cand;
  // cand_valid_vote is a single-cycle pulse with no back-pressure: the counter
  // block must accept it in the cycle it is high, and at most one bit is set.
  btn_t                        cand_valid_vote;
  logic                        ballot_ready;
  logic                        timeout_flag;
  cand_idx_t                   display_sel;
  count_t                      display_count;
  state_t                      dbg_state;

  modport master (
    output mode, arm, button, vote_recv_cand,
    input  cand_valid_vote, ballot_ready, timeout_flag,
    input  display_sel, display_count, dbg_state
  );

  modport slave (
    input  mode, arm, button, vote_recv_cand,
    output cand_valid_vote, ballot_ready, timeout_flag,
    output display_sel, display_count, dbg_state
  );

endinterface

// File: rtl/vote_session_ctrl_press_qualifier.sv
// Classifies a button bundle as none / sole / several pressed and checks the
// sole press against a previously latched candidate index.
module vote_press_qualifier
  import vote_pkg::*;
(
  input  btn_t      i_buttons,
  input  cand_idx_t i_idx,
  output logic      o_zero,
  output logic      o_onehot,
  output cand_idx_t o_idx,
  output logic      o_match
);

  always_comb begin
    o_zero   = (i_buttons == '0);
    o_onehot = $onehot(i_buttons);
    o_idx    = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (i_buttons[i]) o_idx = cand_idx_t'(i);
    end
    o_match  = o_onehot && i_buttons[i_idx];
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot controller: arms one voter per officer strobe, qualifies a held sole
// button into one vote pulse, times out idle ballots and drives result display.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int HOLD_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input logic               clk,
  input logic               rst,
  vote_session_ctrl_if.slave bus
);

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == '1) ? v : v + TMR_ONE;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  cand_idx_t         r_idx, w_idx_nxt;
  logic              r_timeout_flag, w_timeout_nxt;
  logic              r_arm_q;
  btn_t              r_btn_q;
  cand_idx_t         r_display_sel;
  count_t            r_display_count;

  logic      w_arm_rise;
  btn_t      w_btn_rise;
  logic      w_btn_zero, w_btn_onehot, w_btn_match;
  cand_idx_t w_btn_idx;
  logic      w_rise_zero, w_rise_onehot, w_rise_match;
  cand_idx_t w_rise_idx;
  logic      w_sel_load;

  assign w_arm_rise = bus.arm & ~r_arm_q;
  assign w_btn_rise = bus.button & ~r_btn_q;

  vote_press_qualifier u_vote_qual (
    .i_buttons (bus.button),
    .i_idx     (r_idx),
    .o_zero    (w_btn_zero),
    .o_onehot  (w_btn_onehot),
    .o_idx     (w_btn_idx),
    .o_match   (w_btn_match)
  );

  // Result-mode selection works on rising edges, not levels.
  vote_press_qualifier u_sel_qual (
    .i_buttons (w_btn_rise),
    .i_idx     (r_display_sel),
    .o_zero    (w_rise_zero),
    .o_onehot  (w_rise_onehot),
    .o_idx     (w_rise_idx),
    .o_match   (w_rise_match)
  );

  assign w_sel_load = (r_state == ST_RESULT) && bus.mode && !w_rise_zero &&
                      w_rise_onehot && !w_rise_match;

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_idx_nxt     = r_idx;
    w_timeout_nxt = 1'b0;
    if (bus.mode) begin
      w_state_nxt = ST_RESULT;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arm_rise) begin
            w_state_nxt = ST_ARMED;
            w_timer_nxt = '0;
          end
        end
        ST_ARMED: begin
          if (w_btn_onehot) begin
            w_state_nxt = ST_HOLD;
            w_timer_nxt = TMR_ONE;
            w_idx_nxt   = w_btn_idx;
          end else if (r_timer >= TMO_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_timer_nxt   = '0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_timer_nxt = sat_inc(r_timer);
          end
        end
        ST_HOLD: begin
          // A broken hold reopens a full timeout window for the voter.
          if (!w_btn_match) begin
            w_state_nxt = ST_ARMED;
            w_timer_nxt = '0;
          end else if (r_timer >= HOLD_LAST) begin
            w_state_nxt = ST_COMMIT;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = sat_inc(r_timer);
          end
        end
        ST_COMMIT:   w_state_nxt = ST_WAIT_REL;
        ST_WAIT_REL: if (w_btn_zero) w_state_nxt = ST_IDLE;
        ST_RESULT: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_timer         <= '0;
      r_idx           <= '0;
      r_timeout_flag  <= 1'b0;
      r_arm_q         <= 1'b0;
      r_btn_q         <= '0;
      r_display_sel   <= '0;
      r_display_count <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_idx          <= w_idx_nxt;
      r_timeout_flag <= w_timeout_nxt;
      r_arm_q        <= bus.arm;
      r_btn_q        <= bus.button;
      if (w_sel_load) r_display_sel <= w_rise_idx;
      // Count is forced to zero whenever the controller is in a voting state.
      r_display_count <= (w_state_nxt == ST_RESULT) ?
                         bus.vote_recv_cand[r_display_sel] : '0;
    end
  end

  assign bus.cand_valid_vote = (r_state == ST_COMMIT) ? (btn_t'(1) << r_idx) : '0;
  assign bus.ballot_ready    = (r_state == ST_ARMED) || (r_state == ST_HOLD);
  assign bus.timeout_flag    = r_timeout_flag;
  assign bus.display_sel     = r_display_sel;
  assign bus.display_count   = r_display_count;
  assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: vector table, directed corner sequences and a
// randomized voting run against a ballot-rule reference model.
module tb_vote_session_ctrl;
  import vote_pkg::*;

  localparam int HOLD = 4;
  localparam int TMO  = 20;

  logic clk;
  logic rst;
  vote_session_ctrl_if bus();

  vote_session_ctrl #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .TMR_W          (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / counter block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  count_t counts [4];
  count_t force_cnt [4];
  logic   force_en;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) counts[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) counts[i] <= counts[i] + count_t'(bus.cand_valid_vote[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) bus.vote_recv_cand[i] = force_en ? force_cnt[i] : counts[i];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pulse_cnt;
  logic [3:0] valid_or;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    pulse_cnt += $countones(bus.cand_valid_vote);
    valid_or  |= bus.cand_valid_vote;
  endtask

  task automatic arm_edge();
    bus.arm = 1'b0;
    tick();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  // ---------------- reference model (ballot rules) ----------------
  bit m_open, m_release, m_arm_prev;
  int m_run_cand, m_run_len, m_wait_len, m_pulse_cand;

  function automatic int sole_index(input logic [3:0] b);
    if ($countones(b) != 1) return -1;
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_open = 0; m_release = 0; m_arm_prev = 0;
    m_run_cand = -1; m_run_len = 0; m_wait_len = 0; m_pulse_cand = -1;
  endtask

  task automatic model_step(input logic arm_v, input logic [3:0] b);
    int sole;
    int prev_pulse;
    bit to;
    logic [3:0] v;
    sole = sole_index(b);
    to = 0;
    prev_pulse = m_pulse_cand;
    m_pulse_cand = -1;
    if (prev_pulse >= 0) begin
      m_release = 1;
    end else if (m_release) begin
      if (b == 4'b0000) m_release = 0;
    end else if (!m_open) begin
      if (arm_v && !m_arm_prev) begin
        m_open = 1; m_wait_len = 0; m_run_cand = -1;
      end
    end else if (m_run_cand >= 0) begin
      if (sole == m_run_cand) begin
        m_run_len++;
        if (m_run_len == HOLD) begin
          m_pulse_cand = m_run_cand; m_open = 0; m_run_cand = -1;
        end
      end else begin
        m_run_cand = -1; m_wait_len = 0;
      end
    end else begin
      if (sole >= 0) begin
        m_run_cand = sole; m_run_len = 1;
      end else if (m_wait_len == TMO - 1) begin
        m_open = 0; to = 1;
      end else begin
        m_wait_len++;
      end
    end
    m_arm_prev = arm_v;
    v = (m_pulse_cand >= 0) ? (4'b0001 << m_pulse_cand) : 4'b0000;
    exp_q.push_back({v, m_open, to});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       arm;
    logic [3:0] btn;
    logic [3:0] exp_valid;
    logic       exp_ready;
    state_t     exp_state;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int to_at;
    int rdy_drop;
    int pulse_at;
    logic ready_seen;
    logic [5:0] exp_v;
    int r;

    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, ST_IDLE};
    vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, ST_ARMED};
    vecs[2]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, ST_HOLD};
    vecs[3]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, ST_HOLD};
    vecs[4]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, ST_HOLD};
    vecs[5]  = '{1'b0, 4'b0010, 4'b0010, 1'b0, ST_COMMIT};
    vecs[6]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, ST_WAIT_REL};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, ST_IDLE};
    vecs[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, ST_ARMED};
    vecs[9]  = '{1'b1, 4'b0001, 4'b0000, 1'b1, ST_HOLD};
    vecs[10] = '{1'b1, 4'b0001, 4'b0000, 1'b1, ST_HOLD};
    vecs[11] = '{1'b1, 4'b0001, 4'b0000, 1'b1, ST_HOLD};
    vecs[12] = '{1'b1, 4'b0000, 4'b0000, 1'b1, ST_ARMED};
    vecs[13] = '{1'b1, 4'b0001, 4'b0000, 1'b1, ST_HOLD};
    vecs[14] = '{1'b1, 4'b0001, 4'b0000, 1'b1, ST_HOLD};
    vecs[15] = '{1'b1, 4'b0001, 4'b0000, 1'b1, ST_HOLD};
    vecs[16] = '{1'b1, 4'b0001, 4'b0001, 1'b0, ST_COMMIT};
    vecs[17] = '{1'b1, 4'b0000, 4'b0000, 1'b0, ST_WAIT_REL};
    vecs[18] = '{1'b1, 4'b0000, 4'b0000, 1'b0, ST_IDLE};
    vecs[19] = '{1'b1, 4'b0000, 4'b0000, 1'b0, ST_IDLE};

    // ---------------- reset ----------------
    rst = 1'b0;
    bus.mode = 1'b0; bus.arm = 1'b0; bus.button = 4'b0000;
    force_en = 1'b0;
    for (int i = 0; i < 4; i++) force_cnt[i] = '0;
    pulse_cnt = 0; valid_or = '0;
    #2;
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("rst_flags", {29'b0, bus.ballot_ready, bus.timeout_flag, |bus.cand_valid_vote}, 32'd0);
    check("rst_sel", 32'(bus.display_sel), 32'd0);
    check("rst_count", 32'(bus.display_count), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // ---------------- table: vote cand2, broken hold then vote cand1 ----------------
    for (int i = 0; i < 20; i++) begin
      bus.arm = vecs[i].arm;
      bus.button = vecs[i].btn;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus.cand_valid_vote), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ready", i), 32'(bus.ballot_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_state", i), 32'(bus.dbg_state), 32'(vecs[i].exp_state));
    end

    // ---------------- two buttons together, then timeout ----------------
    bus.button = 4'b0000;
    arm_edge();
    check("s3_armed", 32'(bus.ballot_ready), 32'd1);
    pulse_cnt = 0; to_at = 0; rdy_drop = 0;
    for (int n = 1; n <= 40; n++) begin
      bus.button = (n <= 10) ? 4'b0101 : 4'b0000;
      tick();
      if (bus.timeout_flag) begin
        to_at = n;
        break;
      end
      if (!bus.ballot_ready) rdy_drop++;
    end
    check("s3_timeout_cycle", 32'(to_at), 32'd20);
    check("s3_ready_held", 32'(rdy_drop), 32'd0);
    check("s3_no_pulse", 32'(pulse_cnt), 32'd0);
    check("s3_ready_after", 32'(bus.ballot_ready), 32'd0);
    tick();
    check("s3_flag_one_cycle", 32'(bus.timeout_flag), 32'd0);
    check("s3_idle", 32'(bus.dbg_state), 32'(ST_IDLE));

    // ---------------- long hold, re-arm during WAIT_REL ignored ----------------
    arm_edge();
    bus.button = 4'b0100;
    pulse_cnt = 0; valid_or = '0; pulse_at = 0;
    for (int k = 1; k <= 34; k++) begin
      if (k == 15) bus.arm = 1'b1;
      tick();
      if (bus.cand_valid_vote != 4'b0000 && pulse_at == 0) pulse_at = k;
    end
    check("s4_one_pulse", 32'(pulse_cnt), 32'd1);
    check("s4_pulse_cand3", 32'(valid_or), 32'b0100);
    check("s4_pulse_cycle", 32'(pulse_at), 32'(HOLD));
    bus.button = 4'b0000;
    repeat (4) tick();
    check("s4_no_rearm_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("s4_no_rearm_ready", 32'(bus.ballot_ready), 32'd0);
    bus.arm = 1'b0;
    tick();

    // ---------------- mode override mid-hold, result display ----------------
    pulse_cnt = 0;
    arm_edge();
    bus.button = 4'b1000;
    tick(); tick();
    bus.mode = 1'b1;
    tick();
    check("s5_result", 32'(bus.dbg_state), 32'(ST_RESULT));
    bus.button = 4'b0000; tick();
    bus.button = 4'b0010; tick();
    bus.button = 4'b0000; tick();
    check("s5_sel_cand2", 32'(bus.display_sel), 32'd1);
    check("s5_disp_cand2", 32'(bus.display_count), 32'd1);
    bus.button = 4'b0001; tick();
    bus.button = 4'b0000; tick();
    check("s5_disp_cand1", 32'(bus.display_count), 32'd1);
    bus.button = 4'b0100; tick();
    bus.button = 4'b0000; tick();
    check("s5_disp_cand3", 32'(bus.display_count), 32'd1);
    force_cnt[0] = 8'd5; force_cnt[1] = 8'd7; force_cnt[2] = 8'd0; force_cnt[3] = 8'd9;
    force_en = 1'b1;
    bus.button = 4'b1000; tick();
    check("s5_sel_btn4", 32'(bus.display_sel), 32'd3);
    bus.button = 4'b0000; tick();
    check("s5_count_9", 32'(bus.display_count), 32'd9);
    bus.button = 4'b0011; tick();
    bus.button = 4'b0000; tick();
    check("s5_sel_simul", 32'(bus.display_sel), 32'd3);
    force_cnt[3] = 8'd42;
    tick();
    check("s5_count_track", 32'(bus.display_count), 32'd42);
    bus.mode = 1'b0;
    tick();
    check("s5_exit_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("s5_exit_count", 32'(bus.display_count), 32'd0);
    check("s5_exit_sel", 32'(bus.display_sel), 32'd3);
    check("s5_no_pulse", 32'(pulse_cnt), 32'd0);
    force_en = 1'b0;

    // ---------------- asynchronous reset mid-hold ----------------
    arm_edge();
    bus.button = 4'b1000;
    tick(); tick();
    check("s6_hold", 32'(bus.dbg_state), 32'(ST_HOLD));
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("s6_async_ready", 32'(bus.ballot_ready), 32'd0);
    check("s6_async_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #3 rst = 1'b1;
    pulse_cnt = 0; ready_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      ready_seen |= bus.ballot_ready;
    end
    check("s6_ignored_pulse", 32'(pulse_cnt), 32'd0);
    check("s6_ignored_ready", 32'(ready_seen), 32'd0);
    check("s6_ignored_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    bus.button = 4'b0000;
    tick();

    // ---------------- randomized voting against the model ----------------
    model_reset();
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 8) bus.arm = ~bus.arm;
      if ($urandom_range(0, 99) < 25) begin
        r = $urandom_range(0, 3);
        if (r == 0) bus.button = 4'b0000;
        else if (r == 3) bus.button = 4'($urandom_range(0, 15));
        else bus.button = 4'b0001 << $urandom_range(0, 3);
      end
      tick();
      model_step(bus.arm, bus.button);
      if (exp_q.size() == 0) begin
        check("rand_queue", 32'd0, 32'd1);
      end else begin
        exp_v = exp_q.pop_front();
        check("rand_outputs",
              {26'b0, bus.cand_valid_vote, bus.ballot_ready, bus.timeout_flag},
              {26'b0, exp_v});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Ballot controller that sequences the per-candidate vote counter block.
- Qualifies raw candidate buttons into single-cycle cand*_valid_vote pulses.
- Enforces one vote per officer "arm", applies voter timeout, and drives the result-display mux in result mode.
- Sits between the synchronized front-panel inputs and the vote counter; vote counts are fed back in for display.

Parameters:
- HOLD_CYCLES, 10, consecutive sampled cycles a sole button must be held to count as a vote (≥2).
- TIMEOUT_CYCLES, 1000, cycles an armed ballot may sit without a committed vote before auto-cancel.
- TMR_W, 16, width of the shared hold/timeout counter; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- mode  in  1  0 = voting, 1 = result display
- arm  in  1  officer authorize-one-voter strobe, level, edge-detected internally
- button1..button4  in  1 each  synchronized candidate buttons
- vote_recv_cand1..vote_recv_cand4  in  8 each  current counts from the counter block
- cand1_valid_vote..cand4_valid_vote  out  1 each  one-cycle vote pulse to counter
- ballot_ready  out  1  high in ARMED/HOLD (voter lamp)
- timeout_flag  out  1  one-cycle pulse on ballot timeout
- display_sel  out  2  candidate index shown (0..3)
- display_count  out  8  registered count of selected candidate

Behaviour:
- Reset (rst low, async):
  - state = IDLE; timer = 0.
  - All cand*_valid_vote, ballot_ready, timeout_flag = 0.
  - display_sel = 0; display_count = 0; arm edge register = 0.
- States: IDLE, ARMED, HOLD, COMMIT, WAIT_REL, RESULT. All outputs are registered or decoded from registered state.
- mode=1 overrides everything:
  - From any state, the next state is RESULT.
  - Timer is cleared and any pending ballot is discarded with no vote pulse.
  - A COMMIT already registered in the current cycle still completes; no pulse is suppressed retroactively.
- IDLE:
  - A rising edge of arm (arm=1, previous arm=0) → ARMED, timer = 0.
  - Buttons are ignored.
- ARMED:
  - Exactly one button high → HOLD with timer = 1; that candidate index is latched.
  - Zero or ≥2 buttons high → stay ARMED; the timeout timer increments.
  - Timer reaching TIMEOUT_CYCLES-1 → IDLE, with timeout_flag pulsed one cycle.
- HOLD:
  - Latched button is still the sole one high → timer++.
  - Button has been high at HOLD_CYCLES consecutive edges → COMMIT.
  - Latched button drops, or any other button rises → ARMED with timer = 0 (restarts the timeout window).
- COMMIT (1 cycle):
  - cand<latched>_valid_vote = 1; all other valid outputs stay 0.
  - Next state is WAIT_REL.
  - The pulse appears the cycle after the HOLD_CYCLES-th qualifying sample.
- WAIT_REL:
  - Stay until all buttons are low, then → IDLE.
  - The next voter requires a new arm edge.
- arm edges outside IDLE are ignored; arm held high does not re-arm.
- At most one cand*_valid_vote is high in any cycle. Never pulse while mode=1.
- RESULT:
  - A rising edge on buttonN (single button) sets display_sel = N-1.
  - Simultaneous edges leave display_sel unchanged.
  - display_count <= vote_recv_cand[display_sel], with 1-cycle latency and continuous tracking.
  - mode=0 → IDLE; display_count cleared to 0 the next cycle; display_sel retained.
- In voting states display_count = 0.
- Timer saturates at its maximum; it never wraps.

Decomposition:
- Shared package vote_pkg holds:
  - NUM_CAND = 4.
  - Candidate index type (2 bits).
  - State enum with the six states.
  - Button bundle type.
- One natural sub-module: vote_press_qualifier.
  - Implements the onehot/zero/multi button classification and latched-index compare.
  - Reused by the result-mode select logic.

Test Plan (HOLD_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset, arm edge, button2 high 4 cycles → cand2_valid_vote high exactly 1 cycle, 1 cycle after the 4th sample. Release → IDLE. The counter then shows vote_recv_cand2 = 1.
- Arm, button1 held 3 cycles then released → no pulse, back to ARMED. A further 4-cycle hold → a single cand1 pulse.
- Arm, button1+button3 held together 10 cycles → no pulse, ballot_ready stays 1. Idle to 20 cycles → timeout_flag 1 pulse, ballot_ready = 0.
- Vote cast, button held 30 more cycles, no new arm → exactly one pulse. A second arm while in WAIT_REL is ignored.
- Arm, hold button4 2 cycles, raise mode → no pulse, RESULT. With counts 5/7/0/9, press button4 → display_sel = 3, display_count = 9 the next cycle.
- Drop rst mid-HOLD (asynchronous, between edges) → outputs 0 immediately. After release, the state is IDLE and buttons are ignored until an arm edge.
